// File: rtl/regfile_dump_unit_pkg.sv
// Shared core package: architectural register-file geometry and the
// dump FSM state encoding. Also imported by the register file and decoder.
package regfile_dump_unit_pkg;

  localparam int unsigned XLEN     = 64;
  localparam int unsigned NUM_REGS = 32;
  localparam int unsigned AW       = $clog2(NUM_REGS);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } dump_state_t;

endpackage

// File: rtl/regfile_dump_unit.sv
// regfile_dump_unit
//   Walks x0..x(NUM_REGS-1) through register-file read port 1 and streams
//   each register out as an {index, data} beat over a valid/ready handshake.
//   Also snoops the write port and flags any write to a non-zero rd while busy.
//
// Ports
//   i_clk, i_rst_n     clock, asynchronous active-low reset
//   i_start            one-cycle dump request, honoured only when idle
//   o_busy             dump in progress (through the done pulse)
//   o_rf_raddr         read index to register file rs1
//   i_rf_rdata         combinational read data for o_rf_raddr
//   i_rf_we_snoop      register file write enable
//   i_rf_wa_snoop      register file write address
//   o_out_valid/i_out_ready  beat handshake
//   o_out_index, o_out_data, o_out_last  beat payload
//   o_done             one-cycle pulse after the last beat is accepted
//   o_wr_conflict      sticky write-during-dump flag, cleared by next start
module regfile_dump_unit
  import regfile_dump_unit_pkg::*;
(
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_start,
  output logic            o_busy,
  output logic [AW-1:0]   o_rf_raddr,
  input  logic [XLEN-1:0] i_rf_rdata,
  input  logic            i_rf_we_snoop,
  input  logic [AW-1:0]   i_rf_wa_snoop,
  output logic            o_out_valid,
  input  logic            i_out_ready,
  output logic [AW-1:0]   o_out_index,
  output logic [XLEN-1:0] o_out_data,
  output logic            o_out_last,
  output logic            o_done,
  output logic            o_wr_conflict
);

  dump_state_t     r_state;
  logic [AW-1:0]   r_rd_idx;
  logic            r_busy;
  logic            r_out_valid;
  logic [AW-1:0]   r_out_index;
  logic [XLEN-1:0] r_out_data;
  logic            r_out_last;
  logic            r_done;
  logic            r_wr_conflict;

  logic            w_start_ok;
  logic            w_load;
  logic            w_last_idx;
  logic            w_conflict;

  // The FSM is already back in IDLE during the done cycle, but busy is still
  // high there; gating on busy keeps a start coincident with done ignored.
  assign w_start_ok = (r_state == ST_IDLE) && i_start && !r_busy;
  assign w_load     = (r_state == ST_RUN) && (!r_out_valid || i_out_ready);
  assign w_last_idx = (r_rd_idx == AW'(NUM_REGS - 1));
  assign w_conflict = r_busy && i_rf_we_snoop && (i_rf_wa_snoop != '0);

  assign o_rf_raddr = (r_state == ST_RUN) ? r_rd_idx : '0;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state       <= ST_IDLE;
      r_rd_idx      <= '0;
      r_busy        <= 1'b0;
      r_out_valid   <= 1'b0;
      r_out_index   <= '0;
      r_out_data    <= '0;
      r_out_last    <= 1'b0;
      r_done        <= 1'b0;
      r_wr_conflict <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (r_done) begin
        r_busy <= 1'b0;
      end
      if (w_conflict) begin
        r_wr_conflict <= 1'b1;
      end

      case (r_state)
        ST_IDLE: begin
          if (w_start_ok) begin
            r_state       <= ST_RUN;
            r_rd_idx      <= '0;
            r_busy        <= 1'b1;
            r_wr_conflict <= 1'b0;
          end
        end

        ST_RUN: begin
          // In RUN an accepted beat is always replaced by a new load, so
          // out_valid never drops here.
          if (w_load) begin
            r_out_valid <= 1'b1;
            r_out_index <= r_rd_idx;
            r_out_data  <= i_rf_rdata;
            r_out_last  <= w_last_idx;
            if (w_last_idx) begin
              r_state <= ST_DRAIN;
            end else begin
              r_rd_idx <= r_rd_idx + 1'b1;
            end
          end
        end

        ST_DRAIN: begin
          if (r_out_valid && i_out_ready) begin
            r_out_valid <= 1'b0;
            r_done      <= 1'b1;
            r_state     <= ST_IDLE;
          end
        end

        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign o_busy        = r_busy;
  assign o_out_valid   = r_out_valid;
  assign o_out_index   = r_out_index;
  assign o_out_data    = r_out_data;
  assign o_out_last    = r_out_last;
  assign o_done        = r_done;
  assign o_wr_conflict = r_wr_conflict;

endmodule
